// File: rtl/urisc_pkg.sv
// Shared uRISC definitions: datapath widths, fetch reset/exception addresses,
// the bubble encoding and the fetch-stage enums.
package urisc_pkg;

    localparam int PC_WIDTH   = 16;
    localparam int INST_WIDTH = 16;

    localparam logic [PC_WIDTH-1:0]   RESET_PC   = 16'h0000;
    localparam logic [PC_WIDTH-1:0]   EXC_VECTOR = 16'h0002;
    localparam logic [INST_WIDTH-1:0] NOP_INST   = 16'h0800;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        EXC    = 2'd1,
        HALTED = 2'd2
    } fetch_state_e;

    // What the fetch registers do this cycle.
    typedef enum logic [1:0] {
        ACT_SEQ      = 2'd0,
        ACT_HOLD     = 2'd1,
        ACT_REDIRECT = 2'd2,
        ACT_HALT     = 2'd3
    } fetch_act_e;

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC selection and event priority for the fetch stage.
module fetch_next_pc
    import urisc_pkg::*;
#(
    parameter logic [15:0] EXC_VECTOR = urisc_pkg::EXC_VECTOR
) (
    input  fetch_state_e state,
    input  logic [15:0]  pc,
    input  logic [15:0]  pc_ifid,
    input  logic [15:0]  epc,
    input  logic         inst_valid,
    input  logic         stall,
    input  logic         halt,
    input  logic         illegal_op,
    input  logic         return_execution,
    input  logic         jmp_displacement,
    input  logic [15:0]  jmp_displacement_value,
    input  logic         redirect,
    input  logic [15:0]  redirect_target,
    output fetch_act_e   act,
    output logic [15:0]  next_pc,
    output logic         take_exc,
    output logic         take_rti
);

    logic event_ok;

    // Decode events only count for a real instruction that is actually advancing.
    assign event_ok = inst_valid && !stall;

    always_comb begin
        act      = ACT_SEQ;
        next_pc  = pc + 16'd2;
        take_exc = 1'b0;
        take_rti = 1'b0;
        if (state == HALTED) begin
            act     = ACT_HOLD;
            next_pc = pc;
        end else if (redirect) begin
            act     = ACT_REDIRECT;
            next_pc = redirect_target;
        end else if (stall) begin
            act     = ACT_HOLD;
            next_pc = pc;
        end else if (event_ok && halt) begin
            act     = ACT_HALT;
            next_pc = pc;
        end else if (event_ok && illegal_op) begin
            if (state == RUN) begin
                act      = ACT_REDIRECT;
                next_pc  = EXC_VECTOR;
                take_exc = 1'b1;
            end else begin
                act     = ACT_HALT;
                next_pc = pc;
            end
        end else if (event_ok && return_execution && state == EXC) begin
            act      = ACT_REDIRECT;
            next_pc  = epc;
            take_rti = 1'b1;
        end else if (event_ok && jmp_displacement) begin
            act     = ACT_REDIRECT;
            next_pc = pc_ifid + jmp_displacement_value;
        end
    end

endmodule

// File: rtl/fetch.sv
// uRISC instruction-fetch stage: fetch PC, IF/ID register, EPC and the
// RUN/EXC/HALTED control state.
module fetch
    import urisc_pkg::*;
#(
    parameter logic [15:0] RESET_PC   = urisc_pkg::RESET_PC,
    parameter logic [15:0] EXC_VECTOR = urisc_pkg::EXC_VECTOR,
    parameter logic [15:0] NOP_INST   = urisc_pkg::NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] imem_addr_p1,
    input  logic [15:0] imem_rdata_p1,
    input  logic        stall_p1,
    input  logic        halt_idif_p1,
    input  logic        nop_idif_p1,
    input  logic        illegal_op_idif_p1,
    input  logic        return_execution_idif_p1,
    input  logic        jmp_displacement_idif_p1,
    input  logic [15:0] jmp_displacement_value_idif_p1,
    input  logic        redirect_ixif_p1,
    input  logic [15:0] redirect_target_ixif_p1,
    output logic [15:0] inst_ifid_p1,
    output logic        inst_valid_ifid_p1,
    output logic [15:0] pc_p1,
    output logic [15:0] epc_p1,
    output logic        halted_p1
);

    fetch_state_e state_reg, state_next;
    fetch_act_e   act;
    logic [15:0]  pc_reg, pc_next;
    logic [15:0]  inst_reg;
    logic         valid_reg;
    logic [15:0]  pc_ifid_reg;
    logic [15:0]  epc_reg;
    logic         take_exc, take_rti;
    logic         unused_nop_flag;

    // Decode's NOP flag is informational only.
    assign unused_nop_flag = nop_idif_p1;

    fetch_next_pc #(
        .EXC_VECTOR (EXC_VECTOR)
    ) u_next_pc (
        .state                  (state_reg),
        .pc                     (pc_reg),
        .pc_ifid                (pc_ifid_reg),
        .epc                    (epc_reg),
        .inst_valid             (valid_reg),
        .stall                  (stall_p1),
        .halt                   (halt_idif_p1),
        .illegal_op             (illegal_op_idif_p1),
        .return_execution       (return_execution_idif_p1),
        .jmp_displacement       (jmp_displacement_idif_p1),
        .jmp_displacement_value (jmp_displacement_value_idif_p1),
        .redirect               (redirect_ixif_p1),
        .redirect_target        (redirect_target_ixif_p1),
        .act                    (act),
        .next_pc                (pc_next),
        .take_exc               (take_exc),
        .take_rti               (take_rti)
    );

    always_comb begin
        state_next = state_reg;
        if (act == ACT_HALT) begin
            state_next = HALTED;
        end else if (take_exc) begin
            state_next = EXC;
        end else if (take_rti) begin
            state_next = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= RUN;
            pc_reg      <= RESET_PC;
            inst_reg    <= NOP_INST;
            valid_reg   <= 1'b0;
            pc_ifid_reg <= 16'h0000;
            epc_reg     <= 16'h0000;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            if (take_exc) begin
                epc_reg <= pc_ifid_reg;
            end
            case (act)
                ACT_SEQ: begin
                    inst_reg    <= imem_rdata_p1;
                    pc_ifid_reg <= pc_reg + 16'd2;
                    valid_reg   <= 1'b1;
                end
                ACT_REDIRECT, ACT_HALT: begin
                    // Squash whatever was fetched on the abandoned path.
                    inst_reg  <= NOP_INST;
                    valid_reg <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign imem_addr_p1       = pc_reg;
    assign inst_ifid_p1       = inst_reg;
    assign inst_valid_ifid_p1 = valid_reg;
    assign pc_p1              = pc_ifid_reg;
    assign epc_p1             = epc_reg;
    assign halted_p1          = (state_reg == HALTED);

endmodule

// File: tb/tb_fetch.sv
// Bench for the fetch stage: directed vector table, then random stimulus
// against a behavioural model of the fetch rules.
module tb_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] imem_addr_p1, imem_rdata_p1;
    logic        stall_p1, halt_idif_p1, nop_idif_p1, illegal_op_idif_p1;
    logic        return_execution_idif_p1, jmp_displacement_idif_p1;
    logic [15:0] jmp_displacement_value_idif_p1;
    logic        redirect_ixif_p1;
    logic [15:0] redirect_target_ixif_p1;
    logic [15:0] inst_ifid_p1, pc_p1, epc_p1;
    logic        inst_valid_ifid_p1, halted_p1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // Instruction memory contents: mem[a] = a ^ 0x1234, asynchronous read.
    function automatic logic [15:0] mem(input logic [15:0] a);
        return a ^ 16'h1234;
    endfunction

    assign imem_rdata_p1 = mem(imem_addr_p1);

    fetch dut (
        .clk                            (clk),
        .rst                            (rst),
        .imem_addr_p1                   (imem_addr_p1),
        .imem_rdata_p1                  (imem_rdata_p1),
        .stall_p1                       (stall_p1),
        .halt_idif_p1                   (halt_idif_p1),
        .nop_idif_p1                    (nop_idif_p1),
        .illegal_op_idif_p1             (illegal_op_idif_p1),
        .return_execution_idif_p1       (return_execution_idif_p1),
        .jmp_displacement_idif_p1       (jmp_displacement_idif_p1),
        .jmp_displacement_value_idif_p1 (jmp_displacement_value_idif_p1),
        .redirect_ixif_p1               (redirect_ixif_p1),
        .redirect_target_ixif_p1        (redirect_target_ixif_p1),
        .inst_ifid_p1                   (inst_ifid_p1),
        .inst_valid_ifid_p1             (inst_valid_ifid_p1),
        .pc_p1                          (pc_p1),
        .epc_p1                         (epc_p1),
        .halted_p1                      (halted_p1)
    );

    typedef struct {
        logic        rst, stall, halt, ill, rti, jmp;
        logic [15:0] disp;
        logic        redir;
        logic [15:0] tgt;
        logic [15:0] e_pc, e_inst;
        logic        e_valid;
        logic [15:0] e_pcp1, e_epc;
        logic        e_halted;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, s, h, il, rt, j, input logic [15:0] d,
                                input logic rd, input logic [15:0] tg,
                                input logic [15:0] pc, inst, input logic v,
                                input logic [15:0] pcp1, epc, input logic hl);
        vec_t x;
        x.rst = r; x.stall = s; x.halt = h; x.ill = il; x.rti = rt; x.jmp = j;
        x.disp = d; x.redir = rd; x.tgt = tg;
        x.e_pc = pc; x.e_inst = inst; x.e_valid = v; x.e_pcp1 = pcp1;
        x.e_epc = epc; x.e_halted = hl;
        return x;
    endfunction

    task automatic check(input string name, input int idx, input logic [15:0] act, exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s step %0d: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, s, h, il, rt, j, input logic [15:0] d,
                         input logic rd, input logic [15:0] tg);
        rst = r; stall_p1 = s; halt_idif_p1 = h; illegal_op_idif_p1 = il;
        return_execution_idif_p1 = rt; jmp_displacement_idif_p1 = j;
        jmp_displacement_value_idif_p1 = d; redirect_ixif_p1 = rd;
        redirect_target_ixif_p1 = tg; nop_idif_p1 = 1'b0;
    endtask

    task automatic check_all(input int idx, input logic [15:0] pc, inst, input logic v,
                             input logic [15:0] pcp1, epc, input logic hl);
        check("imem_addr", idx, imem_addr_p1, pc);
        check("inst_ifid", idx, inst_ifid_p1, inst);
        check("inst_valid", idx, {15'd0, inst_valid_ifid_p1}, {15'd0, v});
        check("pc_p1", idx, pc_p1, pcp1);
        check("epc", idx, epc_p1, epc);
        check("halted", idx, {15'd0, halted_p1}, {15'd0, hl});
    endtask

    // Behavioural model: architectural state kept as plain variables.
    localparam int M_RUN = 0, M_EXC = 1, M_HALT = 2;
    int          m_mode;
    logic [15:0] m_pc, m_inst, m_pcp1, m_epc;
    logic        m_valid;

    task automatic m_redirect(input logic [15:0] t);
        m_pc = t; m_inst = 16'h0800; m_valid = 1'b0;
    endtask

    task automatic model_step();
        logic ok;
        ok = m_valid && !stall_p1;
        if (rst) begin
            m_mode = M_RUN; m_pc = 16'h0000; m_inst = 16'h0800; m_valid = 1'b0;
            m_pcp1 = 16'h0000; m_epc = 16'h0000;
        end else if (m_mode == M_HALT) begin
            // frozen until reset
        end else if (redirect_ixif_p1) begin
            m_redirect(redirect_target_ixif_p1);
        end else if (stall_p1) begin
            // hold
        end else if (ok && halt_idif_p1) begin
            m_mode = M_HALT; m_inst = 16'h0800; m_valid = 1'b0;
        end else if (ok && illegal_op_idif_p1) begin
            if (m_mode == M_RUN) begin
                m_epc = m_pcp1; m_mode = M_EXC; m_redirect(16'h0002);
            end else begin
                m_mode = M_HALT; m_inst = 16'h0800; m_valid = 1'b0;
            end
        end else if (ok && return_execution_idif_p1 && m_mode == M_EXC) begin
            m_mode = M_RUN; m_redirect(m_epc);
        end else if (ok && jmp_displacement_idif_p1) begin
            m_redirect(m_pcp1 + jmp_displacement_value_idif_p1);
        end else begin
            m_inst = mem(m_pc); m_pcp1 = m_pc + 16'd2; m_pc = m_pc + 16'd2; m_valid = 1'b1;
        end
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 16'h0, 0, 16'h0);

        //          rst s h il rt j disp     rd tgt        pc       inst     v pcp1     epc      hl
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0800, 0, 16'h0000, 16'h0000, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0002, 16'h1234, 1, 16'h0002, 16'h0000, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0004, 16'h1236, 1, 16'h0004, 16'h0000, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0006, 16'h1230, 1, 16'h0006, 16'h0000, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0008, 16'h1232, 1, 16'h0008, 16'h0000, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 16'hFFFC, 0, 16'h0000, 16'h0004, 16'h0800, 0, 16'h0008, 16'h0000, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0006, 16'h1230, 1, 16'h0006, 16'h0000, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0008, 16'h1232, 1, 16'h0008, 16'h0000, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h000A, 16'h123C, 1, 16'h000A, 16'h0000, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h000C, 16'h123E, 1, 16'h000C, 16'h0000, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h000E, 16'h1238, 1, 16'h000E, 16'h0000, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0010, 16'h123A, 1, 16'h0010, 16'h0000, 0));
        // illegal in RUN, then RTI in EXC, then RTI in RUN
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 16'h0000, 0, 16'h0000, 16'h0002, 16'h0800, 0, 16'h0010, 16'h0010, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0004, 16'h1236, 1, 16'h0004, 16'h0010, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 16'h0000, 0, 16'h0000, 16'h0010, 16'h0800, 0, 16'h0004, 16'h0010, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0012, 16'h1224, 1, 16'h0012, 16'h0010, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 16'h0000, 0, 16'h0000, 16'h0014, 16'h1226, 1, 16'h0014, 16'h0010, 0));
        // stall with halt pending: everything holds
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(0, 1, 1, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0014, 16'h1226, 1, 16'h0014, 16'h0010, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 16'h0000, 1, 16'h0040, 16'h0040, 16'h0800, 0, 16'h0014, 16'h0010, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0042, 16'h1274, 1, 16'h0042, 16'h0010, 0));
        // execute redirect beats a same-cycle illegal op
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 16'h0000, 1, 16'h0100, 16'h0100, 16'h0800, 0, 16'h0042, 16'h0010, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0102, 16'h1334, 1, 16'h0102, 16'h0010, 0));
        // double fault halts; halted ignores redirect
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 16'h0000, 0, 16'h0000, 16'h0002, 16'h0800, 0, 16'h0102, 16'h0102, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0004, 16'h1236, 1, 16'h0004, 16'h0102, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 16'h0000, 0, 16'h0000, 16'h0004, 16'h0800, 0, 16'h0004, 16'h0102, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 16'h0000, 1, 16'h0040, 16'h0004, 16'h0800, 0, 16'h0004, 16'h0102, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0004, 16'h0800, 0, 16'h0004, 16'h0102, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0800, 0, 16'h0000, 16'h0000, 0));
        // sequential wrap 0xFFFE -> 0x0000
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 16'h0000, 1, 16'hFFFC, 16'hFFFC, 16'h0800, 0, 16'h0000, 16'h0000, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'hFFFE, 16'hEDC8, 1, 16'hFFFE, 16'h0000, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'hEDCA, 1, 16'h0000, 16'h0000, 0));

        @(posedge clk);
        #1;
        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].stall, tbl[i].halt, tbl[i].ill, tbl[i].rti, tbl[i].jmp,
                  tbl[i].disp, tbl[i].redir, tbl[i].tgt);
            @(posedge clk);
            #1;
            $display("vec %0d: pc=%h inst=%h v=%0b pc_p1=%h epc=%h halted=%0b",
                     i, imem_addr_p1, inst_ifid_p1, inst_valid_ifid_p1, pc_p1, epc_p1, halted_p1);
            check_all(i, tbl[i].e_pc, tbl[i].e_inst, tbl[i].e_valid, tbl[i].e_pcp1,
                      tbl[i].e_epc, tbl[i].e_halted);
        end

        // Randomised run against the model, starting from a reset.
        drive(1, 0, 0, 0, 0, 0, 16'h0, 0, 16'h0);
        model_step();
        @(posedge clk);
        #1;
        check_all(1000, m_pc, m_inst, m_valid, m_pcp1, m_epc, m_mode == M_HALT);
        for (int c = 0; c < 3000; c++) begin
            int k;
            k = $urandom_range(0, 39);
            drive($urandom_range(0, 99) < 2, $urandom_range(0, 4) == 0, k == 0,
                  k inside {[1:2]}, k inside {[3:5]}, k inside {[6:9]},
                  16'($urandom) & 16'hFFFE, $urandom_range(0, 19) == 0,
                  16'($urandom) & 16'hFFFE);
            model_step();
            @(posedge clk);
            #1;
            $display("rnd %0d: pc=%h inst=%h v=%0b pc_p1=%h epc=%h halted=%0b",
                     c, imem_addr_p1, inst_ifid_p1, inst_valid_ifid_p1, pc_p1, epc_p1, halted_p1);
            check_all(2000 + c, m_pc, m_inst, m_valid, m_pcp1, m_epc, m_mode == M_HALT);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
